// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared encodings and frame-length helper for the UART TX scheduler.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

    // Cycles the line stays occupied by one frame, guard idle time included.
    function automatic int frame_cycles(input int frame_bits,
                                        input int clks_per_bit,
                                        input int guard);
        return frame_bits * clks_per_bit + guard;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_8.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo_8
// Brief  : Byte-wide synchronous FIFO with registered full and sticky overflow.
// Rev    : 1.0
// ============================================================================
module sync_fifo_8 #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     C_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   C_PTR_ONE  = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_overflow;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic [AW:0]   w_count_nxt;

    // Full is the registered flag, so a push in the same cycle as a pop from
    // a full FIFO is still rejected.
    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (i_push && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_sched
// Brief  : Round-robin scheduler sharing one UART transmitter between a CPU
//          FIFO and a debug valid/ready source, paced by a frame-time counter.
// Rev    : 1.0
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_BITS   = 10,
    parameter int GUARD        = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_cpu_wen,
    input  logic [7:0]                    i_cpu_wdata,
    output logic                          o_cpu_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_cpu_count,
    output logic                          o_cpu_overflow,
    input  logic                          i_dbg_valid,
    input  logic [7:0]                    i_dbg_data,
    output logic                          o_dbg_ready,
    output logic                          o_tx_en,
    output logic [7:0]                    o_tx_data,
    output logic                          o_busy
);

    localparam int               FRAME_CYC  = frame_cycles(FRAME_BITS, CLKS_PER_BIT, GUARD);
    localparam int               CNT_W      = $clog2(FRAME_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    grant_t                        r_last;
    grant_t                        w_grant;
    logic                          w_grant_vld;
    logic                          w_pop;
    logic                          w_req_cpu;
    logic                          w_req_dbg;
    logic [CNT_W-1:0]              r_cnt;
    logic [7:0]                    r_tx_data;
    logic [7:0]                    w_fifo_data;
    logic [$clog2(FIFO_DEPTH):0]   w_fifo_count;

    sync_fifo_8 #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (i_cpu_wen),
        .i_data     (i_cpu_wdata),
        .i_pop      (w_pop),
        .o_data     (w_fifo_data),
        .o_full     (o_cpu_full),
        .o_count    (w_fifo_count),
        .o_overflow (o_cpu_overflow)
    );

    assign w_req_cpu = (w_fifo_count != '0);
    assign w_req_dbg = i_dbg_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = GNT_CPU;
        w_grant_vld = 1'b0;
        w_pop       = 1'b0;
        o_dbg_ready = 1'b0;
        o_tx_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (w_req_cpu && w_req_dbg) begin
                    w_grant_vld = 1'b1;
                    w_grant     = (r_last == GNT_CPU) ? GNT_DBG : GNT_CPU;
                end else if (w_req_cpu) begin
                    w_grant_vld = 1'b1;
                    w_grant     = GNT_CPU;
                end else if (w_req_dbg) begin
                    w_grant_vld = 1'b1;
                    w_grant     = GNT_DBG;
                end
                if (w_grant_vld) begin
                    w_state_nxt = ST_LOAD;
                    w_pop       = (w_grant == GNT_CPU);
                    o_dbg_ready = (w_grant == GNT_DBG);
                end
            end
            ST_LOAD: begin
                o_tx_en     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= GNT_DBG;
            r_cnt     <= '0;
            r_tx_data <= 8'h00;
        end else begin
            if (w_grant_vld) begin
                r_tx_data <= (w_grant == GNT_CPU) ? w_fifo_data : i_dbg_data;
                r_last    <= w_grant;
            end
            if (r_state == ST_LOAD) begin
                r_cnt <= C_CNT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - C_CNT_ONE;
            end
        end
    end

    assign o_cpu_count = w_fifo_count;
    assign o_tx_data   = r_tx_data;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_sched
// Brief  : Self-checking bench: cycle-level reference model plus directed
//          literal checks and randomized CPU/debug traffic.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_sched;

    localparam int DEPTH     = 4;
    localparam int CPB       = 4;
    localparam int FBITS     = 10;
    localparam int GRD       = 2;
    localparam int FRAME_CYC = FBITS * CPB + GRD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_wen;
    logic [7:0] cpu_wdata;
    logic       cpu_full;
    logic [2:0] cpu_count;
    logic       cpu_overflow;
    logic       dbg_valid;
    logic [7:0] dbg_data;
    logic       dbg_ready;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       busy;

    uart_tx_sched #(
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FBITS),
        .GUARD        (GRD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cpu_wen      (cpu_wen),
        .i_cpu_wdata    (cpu_wdata),
        .o_cpu_full     (cpu_full),
        .o_cpu_count    (cpu_count),
        .o_cpu_overflow (cpu_overflow),
        .i_dbg_valid    (dbg_valid),
        .i_dbg_data     (dbg_data),
        .o_dbg_ready    (dbg_ready),
        .o_tx_en        (tx_en),
        .o_tx_data      (tx_data),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: FIFO as a queue, scheduler as "free again at cycle N".
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic [7:0] m_txd;
    int         m_last;
    int         m_idle_at;
    int         m_pulse;

    int         pulse_c[$];
    logic [7:0] pulse_d[$];
    int         rdy_c[$];
    bit         dbg_taken;
    bit         rnd_dbg;
    logic [7:0] dbg_src[$];
    bit         ovf_seen;
    int         ovf_rise;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit idle, req_c, req_d, g_c, g_d;
        int pre;
        if (!rst_n) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_txd     = 8'h00;
            m_last    = 1;
            m_idle_at = 0;
            m_pulse   = -1;
            dbg_taken = 1'b0;
            ovf_seen  = 1'b0;
            chk("rst_busy",  busy,         0);
            chk("rst_txen",  tx_en,        0);
            chk("rst_txdat", tx_data,      0);
            chk("rst_count", cpu_count,    0);
            chk("rst_full",  cpu_full,     0);
            chk("rst_ovf",   cpu_overflow, 0);
            chk("rst_rdy",   dbg_ready,    0);
        end else begin
            idle  = (cyc >= m_idle_at);
            req_c = (m_q.size() != 0);
            req_d = dbg_valid;
            g_c   = idle && req_c && (!req_d || m_last == 1);
            g_d   = idle && req_d && (!req_c || m_last == 0);
            chk("tx_en",    tx_en,        (cyc == m_pulse));
            chk("busy",     busy,         !idle);
            chk("tx_data",  tx_data,      m_txd);
            chk("count",    cpu_count,    m_q.size());
            chk("full",     cpu_full,     (m_q.size() == DEPTH));
            chk("overflow", cpu_overflow, m_ovf);
            chk("dbg_rdy",  dbg_ready,    g_d);
            if (tx_en) begin
                pulse_c.push_back(cyc);
                pulse_d.push_back(tx_data);
            end
            if (dbg_ready) rdy_c.push_back(cyc);
            if (cpu_overflow && !ovf_seen) begin
                ovf_seen = 1'b1;
                ovf_rise = cyc;
            end
            dbg_taken = dbg_ready;
            pre = m_q.size();
            if (g_c) begin
                m_txd  = m_q.pop_front();
                m_last = 0;
            end
            if (g_d) begin
                m_txd  = dbg_data;
                m_last = 1;
            end
            if (g_c || g_d) begin
                m_pulse   = cyc + 1;
                m_idle_at = cyc + FRAME_CYC + 2;
            end
            if (cpu_wen) begin
                if (pre == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(cpu_wdata);
            end
        end
        cyc++;
    end

    // Debug source: holds data stable until accepted.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            dbg_valid = 1'b0;
        end else begin
            if (dbg_valid && dbg_taken) dbg_valid = 1'b0;
            if (!dbg_valid) begin
                if (dbg_src.size() > 0) begin
                    dbg_data  = dbg_src.pop_front();
                    dbg_valid = 1'b1;
                end else if (rnd_dbg && $urandom_range(0, 7) == 0) begin
                    dbg_data  = 8'($urandom);
                    dbg_valid = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        cpu_wen   = 1'b1;
        cpu_wdata = b;
        tick(1);
        cpu_wen   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        cpu_wen = 1'b0;
        rnd_dbg = 1'b0;
        dbg_src.delete();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic start_test(output int t0);
        pulse_c.delete();
        pulse_d.delete();
        rdy_c.delete();
        t0 = cyc;
    endtask

    task automatic chk_pulses(input string tag, input int t0, input int n,
                              input int offs[5], input logic [7:0] dat[5]);
        chk({tag, "_npulse"}, pulse_c.size(), n);
        for (int i = 0; i < n && i < pulse_c.size(); i++) begin
            chk({tag, "_pcyc"}, pulse_c[i] - t0, offs[i]);
            chk({tag, "_pdat"}, pulse_d[i], dat[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int rates[3] = '{4, 40, 80};
        rst_n     = 1'b0;
        cpu_wen   = 1'b0;
        cpu_wdata = 8'h00;
        dbg_valid = 1'b0;
        dbg_data  = 8'h00;
        rnd_dbg   = 1'b0;
        ovf_rise  = 0;
        tick(3);
        rst_n = 1'b1;

        // Single CPU byte.
        start_test(t0);
        push(8'h41);
        tick(55);
        chk_pulses("single", t0, 1, '{2, 0, 0, 0, 0}, '{8'h41, 0, 0, 0, 0});

        // Burst of three.
        do_reset();
        start_test(t0);
        push(8'h01); push(8'h02); push(8'h03);
        tick(140);
        chk_pulses("burst", t0, 3, '{2, 46, 90, 0, 0}, '{8'h01, 8'h02, 8'h03, 0, 0});
        chk("burst_count", cpu_count, 0);

        // Overflow: sixth push is dropped.
        do_reset();
        start_test(t0);
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        tick(230);
        chk_pulses("ovf", t0, 5, '{2, 46, 90, 134, 178},
                   '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
        chk("ovf_sticky", cpu_overflow, 1);
        chk("ovf_rise", ovf_rise - t0, 6);

        // Round-robin between CPU FIFO and debug.
        do_reset();
        start_test(t0);
        push(8'hA0);
        dbg_src.push_back(8'hD0);
        push(8'hA1);
        tick(140);
        chk_pulses("rr", t0, 3, '{2, 46, 90, 0, 0}, '{8'hA0, 8'hD0, 8'hA1, 0, 0});
        chk("rr_nrdy", rdy_c.size(), 1);
        if (rdy_c.size() > 0) chk("rr_rdycyc", rdy_c[0] - t0, 45);

        // Debug offered mid-frame stalls until the next IDLE.
        do_reset();
        start_test(t0);
        push(8'h33);
        tick(9);
        dbg_src.push_back(8'hD5);
        tick(100);
        chk_pulses("stall", t0, 2, '{2, 46, 0, 0, 0}, '{8'h33, 8'hD5, 0, 0, 0});
        chk("stall_nrdy", rdy_c.size(), 1);
        if (rdy_c.size() > 0) chk("stall_rdycyc", rdy_c[0] - t0, 45);

        // Asynchronous reset in the middle of WAIT.
        do_reset();
        start_test(t0);
        for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
        tick(14);
        #1;
        chk("ar_pre_busy",  busy,         1);
        chk("ar_pre_count", cpu_count,    4);
        chk("ar_pre_ovf",   cpu_overflow, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_busy",  busy,         0);
        chk("ar_txen",  tx_en,        0);
        chk("ar_count", cpu_count,    0);
        chk("ar_ovf",   cpu_overflow, 0);
        tick(2);
        rst_n = 1'b1;
        start_test(t0);
        tick(100);
        chk("ar_npulse", pulse_c.size(), 0);

        // Randomized traffic with varying CPU push rates.
        for (int s = 0; s < 6; s++) begin
            do_reset();
            rnd_dbg = 1'b1;
            for (int i = 0; i < 500; i++) begin
                cpu_wen   = ($urandom_range(0, rates[s % 3] - 1) == 0);
                cpu_wdata = 8'($urandom);
                tick(1);
            end
            cpu_wen = 1'b0;
            rnd_dbg = 1'b0;
            tick(200);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
